// File: rtl/data_memory_be.sv
// data_memory_be: DEPTH_WORDS x 32-bit data memory with byte lanes,
// byte/halfword/word loads and stores, sign/zero extension, fault detection
// and a one-cycle registered response.
// Optional feature macro: DMEM_CLEAR_ON_RESET_EN -- when defined, a CLEAR
// state zeroes the whole array one word per cycle after reset (BUSY=1).
module data_memory_be #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic [1:0]  SIZE,
    input  logic        UNS,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        RVALID,
    output logic        ERR,
    output logic        BUSY
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic [31:0]      r_mem [DEPTH_WORDS];
    logic             r_rvalid;
    logic             r_err;
    logic [31:0]      r_rd;

    logic             w_busy;
    logic             w_acc;
    logic             w_fault;
    logic             w_oor;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic             w_clr_we;
    logic [IDX_W-1:0] w_clr_idx;

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_clr_idx;

    // Clear sequencer: walk every index once after reset, then idle for good.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else if (r_state == ST_CLEAR) begin
            if (r_clr_idx == {IDX_W{1'b1}})
                r_state <= ST_IDLE;
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    // Reset is folded in so BUSY reads high for the whole reset interval.
    assign w_busy    = RST || (r_state == ST_CLEAR);
    assign w_clr_we  = !RST && (r_state == ST_CLEAR);
    assign w_clr_idx = r_clr_idx;
`else
    assign w_busy    = 1'b0;
    assign w_clr_we  = 1'b0;
    assign w_clr_idx = '0;
`endif

    // Requests during reset are never taken, so nothing commits under RST.
    assign w_acc = REQ && !w_busy && !RST;
    assign w_idx = A[IDX_W+1:2];
    assign w_oor = (A >> (IDX_W + 2)) != 32'd0;

    // Fault decode, lane enables and lane-replicated store data.
    always_comb begin
        w_fault = w_oor;
        w_be    = 4'b0000;
        w_wdata = WD;
        case (SIZE)
            SZ_B: begin
                w_be    = 4'b0001 << A[1:0];
                w_wdata = {4{WD[7:0]}};
            end
            SZ_H: begin
                w_fault = w_fault || A[0];
                w_be    = A[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WD[15:0]}};
            end
            SZ_W: begin
                w_fault = w_fault || (A[1:0] != 2'b00);
                w_be    = 4'b1111;
            end
            default: w_fault = 1'b1;
        endcase
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        w_word = r_mem[w_idx];
        case (A[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = A[1] ? w_word[31:16] : w_word[15:0];
        case (SIZE)
            SZ_B:    w_load = UNS ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    w_load = UNS ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Storage: clear writes whole words; stores commit at the acceptance edge.
    always_ff @(posedge CLK) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_acc && WE && !w_fault) begin
            for (int b = 0; b < 4; b++)
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
    end

    // Response register: one strobe per accepted request, RD only for good loads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rd     <= '0;
        end else begin
            r_rvalid <= w_acc;
            r_err    <= w_acc && w_fault;
            r_rd     <= (w_acc && !WE && !w_fault) ? w_load : '0;
        end
    end

    // Reset masks a response already in flight.
    assign RVALID = r_rvalid && !RST;
    assign ERR    = r_err && !RST;
    assign RD     = RST ? 32'd0 : r_rd;
    assign BUSY   = w_busy;

endmodule

// File: tb/tb_data_memory_be.sv
// Self-checking bench for data_memory_be against a byte-addressed model.
module tb_data_memory_be;

    localparam int DEPTH = 256;
    localparam int NB    = DEPTH * 4;

    logic        CLK = 1'b0;
    logic        RST, REQ, WE, UNS;
    logic [1:0]  SIZE;
    logic [31:0] A, WD, RD;
    logic        RVALID, ERR, BUSY;

    int total = 0;
    int bad   = 0;
    logic [7:0] mem_b [NB];

    data_memory_be #(.DEPTH_WORDS(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .SIZE(SIZE), .UNS(UNS),
        .A(A), .WD(WD), .RD(RD), .RVALID(RVALID), .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request per call; consecutive calls are back-to-back.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic        fault;
        logic [31:0] exp;
        logic [7:0]  v8;
        logic [15:0] v16;
        fault = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
                (sz == 2'd2 && a % 4 != 0) || (a >= NB);
        exp = 32'd0;
        if (!fault && !we) begin
            case (sz)
                2'd0: begin
                    v8  = mem_b[a];
                    exp = uns ? 32'(v8) : 32'($signed(v8));
                end
                2'd1: begin
                    v16 = {mem_b[a+1], mem_b[a]};
                    exp = uns ? 32'(v16) : 32'($signed(v16));
                end
                default: exp = {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
            endcase
        end
        if (!fault && we)
            for (int i = 0; i < (1 << sz); i++) mem_b[a+i] = wd[8*i +: 8];
        @(negedge CLK);
        REQ = 1'b1; WE = we; SIZE = sz; UNS = uns; A = a; WD = wd;
        @(posedge CLK); #1;
        chk({tag, " rvalid"}, 32'(RVALID), 32'd1);
        chk({tag, " err"},    32'(ERR),    32'(fault));
        chk({tag, " rd"},     RD,          exp);
    endtask

    task automatic idle(input string tag);
        @(negedge CLK);
        REQ = 1'b0;
        @(posedge CLK); #1;
        chk({tag, " rvalid low"}, 32'(RVALID), 32'd0);
    endtask

    // Counts cycles with BUSY=1, starting at the current (just-released) cycle.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (!BUSY) break;
            n++;
            @(negedge CLK);
        end
    endtask

    // Release reset and establish known storage contents in the model.
    task automatic bring_up(input string tag);
        int n;
        @(negedge CLK);
        RST = 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
        count_busy(n);
        chk({tag, " busy cycles"}, 32'(n), 32'd256);
        for (int i = 0; i < NB; i++) mem_b[i] = 8'h00;
`else
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (BUSY) n++;
            @(negedge CLK);
        end
        chk({tag, " busy never"}, 32'(n), 32'd0);
        for (int w = 0; w < DEPTH; w++)
            xact(1'b1, 2'd2, 1'b0, 32'(w * 4), 32'd0, "init");
        idle("init");
`endif
    endtask

    initial begin
        int n;
        logic [31:0] ra, rd;
        logic [2:0]  rs;
        RST = 1'b1; REQ = 1'b0; WE = 1'b0; SIZE = 2'd0; UNS = 1'b0; A = '0; WD = '0;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset rvalid", 32'(RVALID), 32'd0);
        chk("reset err",    32'(ERR),    32'd0);
        chk("reset rd",     RD,          32'd0);
`ifdef DMEM_CLEAR_ON_RESET_EN
        chk("reset busy",   32'(BUSY),   32'd1);
`else
        chk("reset busy",   32'(BUSY),   32'd0);
`endif
        bring_up("first");

        xact(1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0, "load top");
        idle("after top");

        // Lane-merge store/load sequence
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, "st w10");
        xact(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, "st b11");
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "ld w10");
        xact(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, "ld b11 s");
        xact(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, "ld b11 u");
        xact(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, "ld h12 s");
        xact(1'b0, 2'd1, 1'b1, 32'h10, 32'd0, "ld h10 u");
        idle("lanes");

        // Faulting stores must not touch word 0 (where a truncated index lands)
        xact(1'b1, 2'd2, 1'b0, 32'h402, 32'hDEADBEEF, "st misalign");
        xact(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, "st oor");
        xact(1'b1, 2'd3, 1'b0, 32'h0,   32'h12345678, "st size3");
        xact(1'b1, 2'd1, 1'b0, 32'h1,   32'h0000BEEF, "st h odd");
        xact(1'b0, 2'd2, 1'b0, 32'h0,   32'd0, "ld w0");
        xact(1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0, "ld w3fc");
        idle("faults");

        // Store then load in the very next cycle
        xact(1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A55A5A, "b2b st");
        xact(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, "b2b ld");
        idle("b2b");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rs = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, NB - 1);
            if ($urandom_range(0, 3) != 0) ra = ra & ~((rs >= 3'd4 && rs != 3'd7) ? 32'd3 :
                                                       (rs >= 3'd2 && rs != 3'd7) ? 32'd1 : 32'd0);
            rd = $urandom;
            xact(1'($urandom_range(0, 1)),
                 (rs == 3'd7) ? 2'd3 : (rs >= 3'd4) ? 2'd2 : (rs >= 3'd2) ? 2'd1 : 2'd0,
                 1'($urandom_range(0, 1)), ra, rd, "rand");
            if ($urandom_range(0, 7) == 0) idle("rand gap");
        end
        idle("rand end");

        // Reset in the response cycle suppresses the strobe
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b1; SIZE = 2'd2; A = 32'h40; WD = 32'h0BADF00D;
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        chk("rst kill rvalid", 32'(RVALID), 32'd0);
        chk("rst kill err",    32'(ERR),    32'd0);
        @(negedge CLK);
        REQ = 1'b0;
        bring_up("second");

        // Reset pulsed part-way through clearing
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
        repeat (100) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("mid pulse busy", 32'(BUSY), 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        count_busy(n);
        chk("restart busy cycles", 32'(n), 32'd256);
`else
        repeat (100) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("mid pulse busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (BUSY) n++;
            @(negedge CLK);
        end
        chk("restart busy never", 32'(n), 32'd0);
`endif
        xact(1'b1, 2'd1, 1'b0, 32'h3FE, 32'h00008001, "post st h");
        xact(1'b0, 2'd1, 1'b0, 32'h3FE, 32'd0, "post ld h s");
        idle("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
